control_sequencer: RTL

Multicycle control unit for the 8-bit core. Sits directly upstream of the 4×8 register file. It fetches one instruction at a time, decodes it, and sequences register reads, ALU source selection, data-memory handshakes and register write-back. It drives the register file's `readReg1`, `readReg2`, `writeReg` and `sigRegWrite` inputs, plus the PC, ALU and memory control strobes.

---
 rtl/control_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Multicycle control sequencer for the 8-bit core: fetch, decode, execute, memory and
// write-back sequencing with registered Moore strobes and a retired-instruction counter.
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       instrValid,
    input  logic       memReady,
    output logic       instrReq,
    output logic [1:0] readReg1,
    output logic [1:0] readReg2,
    output logic [1:0] writeReg,
    output logic       sigRegWrite,
    output logic       sigAluSrc,
    output logic [7:0] immExt,
    output logic       sigMemRead,
    output logic       sigMemWrite,
    output logic       sigMemToReg,
    output logic       pcWrite,
    output logic       pcSel,
    output logic [7:0] jumpTarget,
    output logic [7:0] instrCount,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } stateT;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpLw  = 2'b01;
    localparam logic [1:0] OpSw  = 2'b10;
    localparam logic [1:0] OpJ   = 2'b11;

    stateT      stateQ, stateD;
    logic [7:0] irQ, irD;
    logic [1:0] opD;
    logic       retire;
    logic       instrReqD, regWriteD, aluSrcD, memReadD, memWriteD, memToRegD;
    logic       pcWriteD, pcSelD;

    always_comb begin
        stateD = StFetch;
        irD    = irQ;
        retire = 1'b0;
        case (stateQ)
            StFetch: begin
                if (instrValid) begin
                    irD    = instr;
                    stateD = StDecode;
                end else begin
                    stateD = StFetch;
                end
            end
            StDecode: stateD = StExec;
            StExec: begin
                case (irQ[7:6])
                    OpAdd:   stateD = StWb;
                    OpJ: begin
                        stateD = StFetch;
                        retire = 1'b1;
                    end
                    default: stateD = StMem;
                endcase
            end
            StMem: begin
                if (!memReady) begin
                    stateD = StMem;
                end else if (irQ[7:6] == OpLw) begin
                    stateD = StWb;
                end else begin
                    stateD = StFetch;
                    retire = 1'b1;
                end
            end
            StWb: begin
                stateD = StFetch;
                retire = 1'b1;
            end
            default: stateD = StFetch;
        endcase
    end

    // Strobes are decoded from the upcoming state so the registered outputs track stateQ.
    assign opD = irD[7:6];

    always_comb begin
        instrReqD = 1'b0;
        regWriteD = 1'b0;
        aluSrcD   = 1'b0;
        memReadD  = 1'b0;
        memWriteD = 1'b0;
        memToRegD = 1'b0;
        pcWriteD  = 1'b0;
        pcSelD    = 1'b0;
        case (stateD)
            StFetch:  instrReqD = 1'b1;
            StDecode: pcWriteD  = 1'b1;
            StExec: begin
                aluSrcD  = (opD == OpLw) || (opD == OpSw);
                pcWriteD = (opD == OpJ);
                pcSelD   = (opD == OpJ);
            end
            StMem: begin
                aluSrcD   = 1'b1;
                memReadD  = (opD == OpLw);
                memWriteD = (opD == OpSw);
            end
            StWb: begin
                regWriteD = 1'b1;
                memToRegD = (opD == OpLw);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ      <= StFetch;
            irQ         <= 8'h00;
            instrCount  <= 8'h00;
            instrReq    <= 1'b1;
            sigRegWrite <= 1'b0;
            sigAluSrc   <= 1'b0;
            sigMemRead  <= 1'b0;
            sigMemWrite <= 1'b0;
            sigMemToReg <= 1'b0;
            pcWrite     <= 1'b0;
            pcSel       <= 1'b0;
        end else begin
            stateQ      <= stateD;
            irQ         <= irD;
            instrCount  <= retire ? instrCount + 8'd1 : instrCount;
            instrReq    <= instrReqD;
            sigRegWrite <= regWriteD;
            sigAluSrc   <= aluSrcD;
            sigMemRead  <= memReadD;
            sigMemWrite <= memWriteD;
            sigMemToReg <= memToRegD;
            pcWrite     <= pcWriteD;
            pcSel       <= pcSelD;
        end
    end

    assign state      = stateQ;
    assign readReg1   = irQ[5:4];
    assign readReg2   = irQ[3:2];
    assign writeReg   = (stateQ == StWb && irQ[7:6] == OpLw) ? irQ[3:2] : irQ[1:0];
    assign immExt     = {{6{irQ[1]}}, irQ[1:0]};
    assign jumpTarget = {{2{irQ[5]}}, irQ[5:0]};

endmodule
